cursor_paleta_ctrl: RTL and testbench
=====================================

// Module: cursor_paleta_ctrl
// PURPOSE
// - Sequencer for the palette-cursor X datapath (CAMBIAR_X): moves the cursor one palette cell per request.
// - Each move erases the old 4-column cell, updates the index, then redraws the new cell.
// - Drives loadx/in_x/plus/sum/C into the datapath and a write strobe toward the framebuffer writer.
// - Sits between the button/input decoder and the paint framebuffer port in PAINT_ASM.
// PARAMETERS
// - NUM_COLORS  16  palette cells; cursor index range 0..NUM_COLORS-1 (<= 16, so 4*idx+3 fits 6 bits)
// - IDX_W       6   width of in_x / cursor index
// PORTS
// - clk         in   1      single clock, rising-edge logic (datapath samples on negedge)
// - rst         in   1      synchronous, active-high reset
// - btn_left    in   1      move request, one-cycle pulse
// - btn_right   in   1      move request, one-cycle pulse
// - redraw      in   1      pulse: draw cursor at current index, no erase
// - fb_ready    in   1      framebuffer accepts the current write
// - loadx       out  1      datapath: load in_x
// - in_x        out  IDX_W  datapath: cursor cell index
// - plus        out  1      datapath: compute out_x this cycle
// - sum         out  1      datapath: 1 = ascending column (4x+C), 0 = descending (4x+3-C)
// - C           out  3      datapath: column step 0..3 (bit 2 always 0)
// - wr_en       out  1      framebuffer write strobe, held until fb_ready
// - wr_erase    out  1      1 = write background colour, 0 = cursor colour
// - busy        out  1      sequence in progress
// - done        out  1      one-cycle pulse at sequence end
// - cur_idx     out  IDX_W  committed cursor index
// BEHAVIOUR
// - Reset: every output 0, cur_idx=0, state IDLE; applies mid-sequence (abort; partial cell left as-is).
// - States: IDLE -> LOAD_OLD -> E_STEP <-> E_WR -> UPDATE -> D_STEP <-> D_WR -> DONE -> IDLE.
// - IDLE: exactly one of btn_left/btn_right -> LOAD_OLD; both or neither -> stay. redraw (no btn) -> UPDATE with idx unchanged.
// - Precedence in IDLE: any btn pulse beats redraw; left+right together is ignored, including a concurrent redraw.
// - LOAD_OLD: loadx=1, in_x=cur_idx, C counter=0, sum latched (right=1, left=0) for the whole move.
// - E_STEP: plus=1, C=k; next cycle E_WR: wr_en=1, wr_erase=1, held until fb_ready sampled high.
// - E_WR with fb_ready: k==3 -> UPDATE, else k+1 -> E_STEP.
// - UPDATE: cur_idx <= new idx; loadx=1, in_x=new idx; k=0.
// - D_STEP/D_WR: same as erase, wr_erase=0; k==3 accepted -> DONE.
// - DONE: done=1 for one cycle; busy=1 in every state except IDLE.
// - Latency with fb_ready tied high: move = 19 cycles request->done; redraw = 10.
// - out_x valid one cycle after plus; wr_en therefore always trails its plus by exactly one cycle.
// - Requests and redraw arriving while busy are dropped, not queued.
// - Index arithmetic mod NUM_COLORS only under the wrap option below.
// CONFIGURATION
// - Macro CURSOR_WRAP_EN defined: left at 0 -> NUM_COLORS-1, right at NUM_COLORS-1 -> 0; full sequence runs.
// - Not defined: move at an edge is ignored entirely (stay IDLE, no writes, no done, busy stays 0).
// STRUCTURE
// - Package cursor_paleta_pkg: state encodings, CELL_W=4, C_LAST=3, background/cursor colour constants.
// - Sub-module cursor_col_sweep: 2-bit column counter with clear, advance and last flag; used by both phases.
// - FSM plus index register stay in cursor_paleta_ctrl.
// TESTING
// - rst, then btn_right, fb_ready=1 -> in_x 0 then 1; C 0,1,2,3 per phase; 4 erase + 4 draw writes; done at cycle 19; cur_idx=1.
// - cur_idx=3, btn_left -> sum=0 in both phases; 4*x+3-C write columns are 15,14,13,12 then 11,10,9,8; cur_idx=2.
// - fb_ready low 3 cycles in E_WR k=1 -> wr_en held, C stays 1, no plus; resumes, total = 22 cycles.
// - cur_idx=0, btn_left -> with CURSOR_WRAP_EN cur_idx=15 after full sequence; without, no busy, no writes.
// - btn_left+btn_right same cycle -> ignored; btn_right while busy -> dropped, single move only.
// - rst asserted in D_STEP k=2 -> next cycle all outputs 0, IDLE; later redraw -> 4 draw writes at cur_idx.

Source files
------------

// File: rtl/cursor_paleta_pkg.sv
// Shared encodings and constants for the palette-cursor X sequencer.
package cursor_paleta_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_OLD,
        S_E_STEP,
        S_E_WR,
        S_UPDATE,
        S_D_STEP,
        S_D_WR,
        S_DONE
    } state_t;

    localparam int         CELL_W       = 4;
    localparam logic [1:0] C_LAST       = 2'(CELL_W - 1);
    localparam logic [3:0] COLOR_BG     = 4'h0;
    localparam logic [3:0] COLOR_CURSOR = 4'hF;

endpackage

// File: rtl/cursor_col_sweep.sv
// Column step counter across one 4-column palette cell; shared by erase and draw phases.
module cursor_col_sweep
    import cursor_paleta_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       adv,
    output logic [1:0] k,
    output logic       last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            k <= '0;
        end else if (adv) begin
            k <= k + 2'd1;
        end
    end

    assign last = (k == C_LAST);

endmodule

// File: rtl/cursor_paleta_ctrl.sv
// Palette-cursor X sequencer: erase old cell, commit new index, redraw new cell.
// Optional macro CURSOR_WRAP_EN makes moves past either palette edge wrap around.
module cursor_paleta_ctrl
    import cursor_paleta_pkg::*;
#(
    parameter int NUM_COLORS = 16,
    parameter int IDX_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             redraw,
    input  logic             fb_ready,
    output logic             loadx,
    output logic [IDX_W-1:0] in_x,
    output logic             plus,
    output logic             sum,
    output logic [2:0]       C,
    output logic             wr_en,
    output logic             wr_erase,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] cur_idx
);

    // wr_en rises one cycle after its plus and holds until fb_ready is seen high;
    // a write completes on the rising edge where wr_en and fb_ready are both 1.
    state_t           state;
    logic [IDX_W-1:0] tgt_idx;
    logic [IDX_W-1:0] move_idx;
    logic [1:0]       col_k;
    logic             col_last, col_clr, col_adv;
    logic             at_left, at_right, move_ok, wr_accept;

    cursor_col_sweep u_sweep (
        .clk  (clk),
        .rst  (rst),
        .clr  (col_clr),
        .adv  (col_adv),
        .k    (col_k),
        .last (col_last)
    );

    assign C = {1'b0, col_k};

    always_comb begin
        at_left  = (cur_idx == '0);
        at_right = (cur_idx == IDX_W'(NUM_COLORS - 1));
        if (btn_right) move_idx = at_right ? '0 : cur_idx + 1'b1;
        else           move_idx = at_left ? IDX_W'(NUM_COLORS - 1) : cur_idx - 1'b1;
`ifdef CURSOR_WRAP_EN
        move_ok = btn_left ^ btn_right;
`else
        move_ok = (btn_left ^ btn_right) && (btn_right ? !at_right : !at_left);
`endif
        wr_accept = ((state == S_E_WR) || (state == S_D_WR)) && fb_ready;
        col_clr   = (state == S_IDLE) || ((state == S_E_WR) && fb_ready && col_last);
        col_adv   = wr_accept && !col_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            loadx    <= 1'b0;
            in_x     <= '0;
            plus     <= 1'b0;
            sum      <= 1'b0;
            wr_en    <= 1'b0;
            wr_erase <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cur_idx  <= '0;
            tgt_idx  <= '0;
        end else begin
            loadx <= 1'b0;
            plus  <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (move_ok) begin
                        state   <= S_LOAD_OLD;
                        loadx   <= 1'b1;
                        in_x    <= cur_idx;
                        sum     <= btn_right;
                        tgt_idx <= move_idx;
                        busy    <= 1'b1;
                    end else if (redraw && !btn_left && !btn_right) begin
                        // Redraw skips erase and paints the current cell ascending.
                        state <= S_UPDATE;
                        loadx <= 1'b1;
                        in_x  <= cur_idx;
                        sum   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD_OLD: begin
                    state <= S_E_STEP;
                    plus  <= 1'b1;
                end
                S_E_STEP: begin
                    state    <= S_E_WR;
                    wr_en    <= 1'b1;
                    wr_erase <= 1'b1;
                end
                S_E_WR: begin
                    if (fb_ready) begin
                        wr_en    <= 1'b0;
                        wr_erase <= 1'b0;
                        if (col_last) begin
                            state   <= S_UPDATE;
                            loadx   <= 1'b1;
                            in_x    <= tgt_idx;
                            cur_idx <= tgt_idx;
                        end else begin
                            state <= S_E_STEP;
                            plus  <= 1'b1;
                        end
                    end
                end
                S_UPDATE: begin
                    state <= S_D_STEP;
                    plus  <= 1'b1;
                end
                S_D_STEP: begin
                    state    <= S_D_WR;
                    wr_en    <= 1'b1;
                    wr_erase <= 1'b0;
                end
                S_D_WR: begin
                    if (fb_ready) begin
                        wr_en <= 1'b0;
                        if (col_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_D_STEP;
                            plus  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cursor_paleta_ctrl.sv
// Directed bench for cursor_paleta_ctrl; honours CURSOR_WRAP_EN for the edge case.
module tb_cursor_paleta_ctrl;

    logic       clk = 1'b0;
    logic       rst, btn_left, btn_right, redraw, fb_ready;
    logic       loadx, plus, sum, wr_en, wr_erase, busy, done;
    logic [5:0] in_x, cur_idx;
    logic [2:0] C;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_idx  = 0;
    int dcyc, busy_cnt, wr_cnt, done_cnt, loads;
    logic found;

    // Expected framebuffer writes: {erase, column}.
    logic [6:0] exp_q[$];

    cursor_paleta_ctrl dut (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
        .redraw(redraw), .fb_ready(fb_ready), .loadx(loadx), .in_x(in_x),
        .plus(plus), .sum(sum), .C(C), .wr_en(wr_en), .wr_erase(wr_erase),
        .busy(busy), .done(done), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push_cell(input logic erase, input int x, input logic asc);
        for (int k = 0; k < 4; k++)
            exp_q.push_back({erase, 6'(asc ? 4 * x + k : 4 * x + 3 - k)});
    endtask

    // kind: 0 left, 1 right, 2 redraw. Stall holds fb_ready low 3 cycles at erase step stall_k.
    task automatic run_seq(input int kind, input int stall_k, input int inject_at, output int done_cyc);
        int stall_left;
        logic prev_plus, prev_wr;
        logic [5:0] x, col;
        stall_left = 3; prev_plus = 0; prev_wr = 0; x = '0; done_cyc = -1;
        @(negedge clk);
        btn_left = (kind == 0); btn_right = (kind == 1); redraw = (kind == 2);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            btn_left = 0; btn_right = (n == inject_at); redraw = 0; fb_ready = 1;
            if (wr_en && wr_erase && int'(C) == stall_k && stall_left > 0) begin
                fb_ready = 0;
                stall_left--;
                check("stall_no_plus", plus, 0);
            end
            if (loadx) x = in_x;
            if (wr_en && !prev_wr) check("wr_trails_plus", prev_plus, 1);
            if (wr_en && fb_ready) begin
                col = sum ? 6'(4 * x + C) : 6'(4 * x + 3 - C);
                if (exp_q.size() == 0) check("extra_write", {wr_erase, col}, -1);
                else check("write", {wr_erase, col}, exp_q.pop_front());
            end
            if (done) begin
                done_cyc = n;
                break;
            end
            prev_plus = plus; prev_wr = wr_en;
        end
        btn_right = 0;
        check("writes_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic watch_idle(input int cycles, output int b_cnt, output int w_cnt, output int d_cnt);
        b_cnt = 0; w_cnt = 0; d_cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            btn_left = 0; btn_right = 0; redraw = 0;
            if (busy) b_cnt++;
            if (wr_en) w_cnt++;
            if (done) d_cnt++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_erase"}, wr_erase, 0);
        check({tag, "_loadx"}, loadx, 0);
        check({tag, "_plus"}, plus, 0);
        check({tag, "_sum"}, sum, 0);
        check({tag, "_C"}, C, 0);
        check({tag, "_in_x"}, in_x, 0);
        check({tag, "_cur_idx"}, cur_idx, 0);
    endtask

    initial begin
        rst = 1; btn_left = 0; btn_right = 0; redraw = 0; fb_ready = 1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 0;

        // 0 -> 1 with a second request dropped mid-sequence.
        push_cell(1, 0, 1); push_cell(0, 1, 1);
        run_seq(1, -1, 5, dcyc);
        check("right01_latency", dcyc, 19);
        check("right01_idx", cur_idx, 1);
        check("right01_sum", sum, 1);
        watch_idle(10, busy_cnt, wr_cnt, done_cnt);
        check("dropped_req_busy", busy_cnt, 0);
        check("dropped_req_idx", cur_idx, 1);

        push_cell(1, 1, 1); push_cell(0, 2, 1);
        run_seq(1, -1, -1, dcyc);
        check("right12_latency", dcyc, 19);
        check("right12_idx", cur_idx, 2);

        // Stall three cycles at erase column step 1.
        push_cell(1, 2, 1); push_cell(0, 3, 1);
        run_seq(1, 1, -1, dcyc);
        check("stall_latency", dcyc, 22);
        check("stall_idx", cur_idx, 3);

        // 3 -> 2 descending: columns 15..12 then 11..8.
        push_cell(1, 3, 0); push_cell(0, 2, 0);
        run_seq(0, -1, -1, dcyc);
        check("left32_latency", dcyc, 19);
        check("left32_idx", cur_idx, 2);
        check("left32_sum", sum, 0);

        for (int i = 2; i > 0; i--) begin
            push_cell(1, i, 0); push_cell(0, i - 1, 0);
            run_seq(0, -1, -1, dcyc);
            check("left_latency", dcyc, 19);
            check("left_idx", cur_idx, i - 1);
        end

        // Both buttons plus redraw in one cycle: nothing happens.
        @(negedge clk);
        btn_left = 1; btn_right = 1; redraw = 1;
        watch_idle(20, busy_cnt, wr_cnt, done_cnt);
        check("both_busy", busy_cnt, 0);
        check("both_writes", wr_cnt, 0);
        check("both_idx", cur_idx, 0);

`ifdef CURSOR_WRAP_EN
        push_cell(1, 0, 0); push_cell(0, 15, 0);
        run_seq(0, -1, -1, dcyc);
        check("wrap_latency", dcyc, 19);
        check("wrap_idx", cur_idx, 15);
        exp_idx = 15;
`else
        @(negedge clk);
        btn_left = 1;
        watch_idle(20, busy_cnt, wr_cnt, done_cnt);
        check("edge_busy", busy_cnt, 0);
        check("edge_writes", wr_cnt, 0);
        check("edge_done", done_cnt, 0);
        check("edge_idx", cur_idx, 0);
`endif

        // Reset during draw step 2 aborts the move.
        @(negedge clk);
        if (exp_idx == 15) btn_left = 1; else btn_right = 1;
        loads = 0; found = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            btn_left = 0; btn_right = 0;
            if (loadx) loads++;
            if (loads == 2 && plus && C == 3'd2) begin
                found = 1;
                break;
            end
        end
        check("reach_dstep2", found, 1);
        rst = 1;
        @(negedge clk);
        check_all_zero("midreset");
        rst = 0;

        push_cell(0, 0, 1);
        run_seq(2, -1, -1, dcyc);
        check("redraw_latency", dcyc, 10);
        check("redraw_idx", cur_idx, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
